// File: rtl/hdmi_line_fetch_ctrl.sv
// rtl/hdmi_line_fetch_ctrl.sv - 2x-scaled ping-pong line fetch scheduler between frame buffer and HDMI driver
//
// Purpose:
//   Prefetches one RGB565 source row per two display lines from the frame
//   buffer into a two-bank line buffer and serves pixels to the video driver
//   with fixed 2x horizontal/vertical scaling.
//
// Ports:
//   hdmi_clk, rst          pixel clock, asynchronous active-high reset
//   pixel_xpos, pixel_ypos current display column / line from the driver
//   line_done, frame_start line / frame timing pulses from the driver
//   fb_base                frame base word address, sampled on frame_start
//   mem_req/addr/gnt       in-order read request port to the frame buffer
//   mem_rvalid/rdata       read return port, data in issue order
//   rd_data, IsGameWindow  pixel and window flag, one cycle after xpos/ypos
//   underrun               sticky: displayed bank swapped before its fetch completed

module hdmi_line_fetch_ctrl #(
    parameter int          SRC_W  = 256,
    parameter int          SRC_H  = 240,
    parameter int          X_OFF  = 64,
    parameter int          ADDR_W = 18,
    parameter logic [15:0] BORDER = 16'h0000
) (
    input  logic              hdmi_clk,
    input  logic              rst,
    input  logic [11:0]       pixel_xpos,
    input  logic [11:0]       pixel_ypos,
    input  logic              line_done,
    input  logic              frame_start,
    input  logic [ADDR_W-1:0] fb_base,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [15:0]       mem_rdata,
    output logic [15:0]       rd_data,
    output logic              IsGameWindow,
    output logic              underrun
);

    localparam int LW = $clog2(SRC_W);
    localparam int RW = $clog2(SRC_H);
    localparam int KW = LW + 1;
    localparam int NW = LW + 2;

    localparam logic [11:0]   X_LO       = 12'(X_OFF);
    localparam logic [11:0]   X_HI       = 12'(X_OFF + 2 * SRC_W);
    localparam logic [11:0]   Y_HI       = 12'(2 * SRC_H);
    // Even lines below this prefetch the next row; odd lines below Y_ODD_LIM swap.
    localparam logic [11:0]   Y_EVEN_LIM = 12'(2 * SRC_H - 2);
    localparam logic [11:0]   Y_ODD_LIM  = 12'(2 * SRC_H - 1);
    localparam logic [LW-1:0] I_LAST     = LW'(SRC_W - 1);
    localparam logic [KW-1:0] K_FULL     = KW'(SRC_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              fbank_q, fbank_d;
    logic              row0_q, row0_d;
    logic [LW-1:0]     iss_idx_q, iss_idx_d;
    logic [KW-1:0]     ret_idx_q, ret_idx_d;
    logic [NW-1:0]     outst_q, outst_d;
    logic              discard_q, discard_d;
    logic              pend0_q, pend0_d;
    logic              fetch_done_q, fetch_done_d;
    logic              cur_bank_q, cur_bank_d;
    logic              underrun_q, underrun_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]       rd_data_q, rd_data_d;
    logic              win_q, win_d;

    logic [15:0]       line_mem [0:2*SRC_W-1];
    logic              we;
    logic [LW:0]       waddr;

    logic              grant, ret, line_even, line_odd, in_win;
    logic              start, start_bank;
    logic [RW-1:0]     start_row;
    logic [ADDR_W-1:0] start_base;
    logic [LW-1:0]     pix_idx;

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        fbank_d      = fbank_q;
        row0_d       = row0_q;
        iss_idx_d    = iss_idx_q;
        ret_idx_d    = ret_idx_q;
        outst_d      = outst_q;
        discard_d    = discard_q;
        pend0_d      = pend0_q;
        fetch_done_d = fetch_done_q;
        cur_bank_d   = cur_bank_q;
        underrun_d   = underrun_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        we           = 1'b0;
        waddr        = {fbank_q, ret_idx_q[LW-1:0]};
        start        = 1'b0;
        start_bank   = 1'b0;
        start_row    = '0;
        start_base   = base_q;

        grant     = mem_req_q && mem_gnt;
        // A return with nothing outstanding belongs to a request issued before reset.
        ret       = mem_rvalid && (outst_q != '0);
        line_even = line_done && !pixel_ypos[0] && (pixel_ypos < Y_EVEN_LIM);
        line_odd  = line_done &&  pixel_ypos[0] && (pixel_ypos < Y_ODD_LIM);

        if (grant && !ret) begin
            outst_d = outst_q + NW'(1);
        end else if (!grant && ret) begin
            outst_d = outst_q - NW'(1);
        end

        if (ret && !discard_q) begin
            we        = 1'b1;
            ret_idx_d = ret_idx_q + KW'(1);
            if (ret_idx_d == K_FULL) begin
                fetch_done_d = 1'b1;
                // Row 0 is fetched in vertical blank; it becomes visible when complete.
                if (row0_q) begin
                    cur_bank_d = 1'b0;
                end
            end
        end
        if (discard_q && (outst_d == '0)) begin
            discard_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (pend0_q && (outst_q == '0)) begin
                    start = 1'b1;
                end else if (line_even && (outst_q == '0) && !pend0_q) begin
                    start      = 1'b1;
                    start_row  = RW'(pixel_ypos >> 1) + RW'(1);
                    start_bank = ~cur_bank_q;
                end
            end
            S_ISSUE: begin
                if (grant) begin
                    if (iss_idx_q == I_LAST) begin
                        state_d   = S_DRAIN;
                        mem_req_d = 1'b0;
                    end else begin
                        iss_idx_d  = iss_idx_q + LW'(1);
                        mem_addr_d = mem_addr_q + ADDR_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (outst_q == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (line_odd) begin
            cur_bank_d = ~cur_bank_q;
            if (!fetch_done_q) begin
                underrun_d = 1'b1;
            end
        end

        // frame_start restarts the frame: it either launches row 0 at once from
        // the new base, or aborts the current fetch and lets row 0 start once
        // every old return has been swallowed.
        if (frame_start) begin
            base_d = fb_base;
            if ((state_q == S_IDLE) && (outst_q == '0)) begin
                start      = 1'b1;
                start_row  = '0;
                start_bank = 1'b0;
                start_base = fb_base;
            end else begin
                start     = 1'b0;
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
                pend0_d   = 1'b1;
                discard_d = (outst_d != '0);
            end
        end

        if (start) begin
            state_d      = S_ISSUE;
            mem_req_d    = 1'b1;
            mem_addr_d   = start_base + ADDR_W'({start_row, {LW{1'b0}}});
            fbank_d      = start_bank;
            row0_d       = (start_row == '0);
            iss_idx_d    = '0;
            ret_idx_d    = '0;
            fetch_done_d = 1'b0;
            discard_d    = 1'b0;
            pend0_d      = 1'b0;
        end

        in_win    = (pixel_xpos >= X_LO) && (pixel_xpos < X_HI) && (pixel_ypos < Y_HI);
        pix_idx   = LW'((pixel_xpos - X_LO) >> 1);
        win_d     = in_win;
        rd_data_d = in_win ? line_mem[{cur_bank_q, pix_idx}] : BORDER;
    end

    always_ff @(posedge hdmi_clk) begin
        if (we) begin
            line_mem[waddr] <= mem_rdata;
        end
    end

    always_ff @(posedge hdmi_clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            fbank_q      <= 1'b0;
            row0_q       <= 1'b0;
            iss_idx_q    <= '0;
            ret_idx_q    <= '0;
            outst_q      <= '0;
            discard_q    <= 1'b0;
            pend0_q      <= 1'b0;
            fetch_done_q <= 1'b0;
            cur_bank_q   <= 1'b0;
            underrun_q   <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            rd_data_q    <= '0;
            win_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            fbank_q      <= fbank_d;
            row0_q       <= row0_d;
            iss_idx_q    <= iss_idx_d;
            ret_idx_q    <= ret_idx_d;
            outst_q      <= outst_d;
            discard_q    <= discard_d;
            pend0_q      <= pend0_d;
            fetch_done_q <= fetch_done_d;
            cur_bank_q   <= cur_bank_d;
            underrun_q   <= underrun_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            rd_data_q    <= rd_data_d;
            win_q        <= win_d;
        end
    end

    assign mem_req      = mem_req_q;
    assign mem_addr     = mem_addr_q;
    assign rd_data      = rd_data_q;
    assign IsGameWindow = win_q;
    assign underrun     = underrun_q;

endmodule
